// File: rtl/hazard_ctrl_if.sv
// Decode-stage hazard bus: the D-stage instruction fields and multiply/divide status
// go in, and stall plus the forwarding selects come out.
interface hazard_ctrl_if;
    logic       d_valid;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] d_tuse_rs;
    logic [1:0] d_tuse_rt;
    logic [4:0] d_dst;
    logic [1:0] d_tnew;
    logic       d_is_md;
    logic       md_start;
    logic       md_busy;
    logic       stall;
    logic [1:0] fwd_d_rs;
    logic [1:0] fwd_d_rt;
    logic [1:0] fwd_e_rs;
    logic [1:0] fwd_e_rt;

    modport master (
        output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew, d_is_md,
        output md_start, md_busy,
        input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew, d_is_md,
        input  md_start, md_busy,
        output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Tuse/Tnew hazard unit for a 5-stage MIPS pipeline, driven by a shadow E/M/W pipeline.
// Optional macro HAZARD_STATS_EN adds a 32-bit stall_cnt output port.
module hazard_ctrl (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]  stall_cnt
`endif
);

    logic [4:0] e_dst_q, e_dst_d, e_rs_q, e_rs_d, e_rt_q, e_rt_d;
    logic [1:0] e_tnew_q, e_tnew_d;
    logic [4:0] m_dst_q, m_dst_d;
    logic [1:0] m_tnew_q, m_tnew_d;
    logic [4:0] w_dst_q, w_dst_d;
    logic       haz_rs, haz_rt, haz_md;

    function automatic logic src_haz(input logic [4:0] s, input logic [1:0] tuse,
                                     input logic [4:0] ed, input logic [1:0] et,
                                     input logic [4:0] md, input logic [1:0] mt);
        return (s != 5'd0) && (tuse != 2'd3) &&
               (((ed == s) && (et > tuse)) || ((md == s) && (mt > tuse)));
    endfunction

    // E never forwards: its result is not ready before it reaches M with tnew 0.
    function automatic logic [1:0] fwd_sel(input logic [4:0] s, input logic [4:0] md,
                                           input logic [1:0] mt, input logic [4:0] wd);
        if (s == 5'd0)                  return 2'd0;
        if ((md == s) && (mt == 2'd0))  return 2'd1;
        if (wd == s)                    return 2'd2;
        return 2'd0;
    endfunction

    always_comb begin
        haz_rs      = src_haz(hz.d_rs, hz.d_tuse_rs, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
        haz_rt      = src_haz(hz.d_rt, hz.d_tuse_rt, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
        haz_md      = hz.d_is_md & (hz.md_start | hz.md_busy);
        hz.stall    = hz.d_valid & (haz_rs | haz_rt | haz_md);
        hz.fwd_d_rs = fwd_sel(hz.d_rs, m_dst_q, m_tnew_q, w_dst_q);
        hz.fwd_d_rt = fwd_sel(hz.d_rt, m_dst_q, m_tnew_q, w_dst_q);
        hz.fwd_e_rs = fwd_sel(e_rs_q,  m_dst_q, m_tnew_q, w_dst_q);
        hz.fwd_e_rt = fwd_sel(e_rt_q,  m_dst_q, m_tnew_q, w_dst_q);
    end

    // M and W always advance; only the E slot takes a bubble on a stall.
    always_comb begin
        w_dst_d  = m_dst_q;
        m_dst_d  = e_dst_q;
        m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
        e_dst_d  = 5'd0;
        e_tnew_d = 2'd0;
        e_rs_d   = 5'd0;
        e_rt_d   = 5'd0;
        if (hz.d_valid && !hz.stall) begin
            e_dst_d  = hz.d_dst;
            e_tnew_d = hz.d_tnew;
            e_rs_d   = hz.d_rs;
            e_rt_d   = hz.d_rt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_dst_q  <= 5'd0;
            e_tnew_q <= 2'd0;
            e_rs_q   <= 5'd0;
            e_rt_q   <= 5'd0;
            m_dst_q  <= 5'd0;
            m_tnew_q <= 2'd0;
            w_dst_q  <= 5'd0;
        end else begin
            e_dst_q  <= e_dst_d;
            e_tnew_q <= e_tnew_d;
            e_rs_q   <= e_rs_d;
            e_rt_q   <= e_rt_d;
            m_dst_q  <= m_dst_d;
            m_tnew_q <= m_tnew_d;
            w_dst_q  <= w_dst_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hz.stall) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= 32'd0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, ALU-branch, MD interlock, forward priority,
// register zero and reset-during-stall, with hand-computed expectations.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   ntests = 0;
    int   nfail  = 0;

    hazard_ctrl_if bus ();

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
    hazard_ctrl dut (.clk(clk), .reset(reset), .hz(bus.slave), .stall_cnt(stall_cnt));
`else
    hazard_ctrl dut (.clk(clk), .reset(reset), .hz(bus.slave));
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // valid, rs, tuse_rs, rt, tuse_rt, dst, tnew, is_md
    task automatic d_set(input logic v, input logic [4:0] rs, input logic [1:0] urs,
                         input logic [4:0] rt, input logic [1:0] urt,
                         input logic [4:0] dst, input logic [1:0] tnew, input logic md);
        bus.d_valid   = v;
        bus.d_rs      = rs;
        bus.d_tuse_rs = urs;
        bus.d_rt      = rt;
        bus.d_tuse_rt = urt;
        bus.d_dst     = dst;
        bus.d_tnew    = tnew;
        bus.d_is_md   = md;
    endtask

    task automatic d_idle();
        d_set(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    endtask

    // Inputs change just after the falling edge; checks run 1ns later.
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        reset        = 1'b1;
        bus.md_start = 1'b0;
        bus.md_busy  = 1'b0;
        d_idle();
        repeat (2) @(posedge clk);
        cyc(); reset = 1'b0; #1;
        chk("rst_stall", bus.stall, 0);
        chk("rst_fwd_d_rs", bus.fwd_d_rs, 0);
        chk("rst_fwd_e_rs", bus.fwd_e_rs, 0);
        chk("rst_fwd_e_rt", bus.fwd_e_rt, 0);
`ifdef HAZARD_STATS_EN
        chk("rst_cnt", stall_cnt, 0);
`endif

        // Load-use: lw $8 then addu $10,$8,$9
        d_set(1, 5'd29, 1, 5'd0, 3, 5'd8, 2, 0); #1;
        chk("lw_no_stall", bus.stall, 0);
        cyc(); d_set(1, 5'd8, 1, 5'd9, 1, 5'd10, 1, 0); #1;
        chk("ldu_stall", bus.stall, 1);
        cyc(); #1;
        chk("ldu_release", bus.stall, 0);
        chk("ldu_fwd_d_rs", bus.fwd_d_rs, 0);
        cyc(); d_idle(); #1;
        chk("ldu_fwd_e_rs", bus.fwd_e_rs, 2);
        chk("ldu_fwd_e_rt", bus.fwd_e_rt, 0);

        // ALU then branch: addu $9 then beq $9,$0
        cyc(); d_set(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0); #1;
        chk("alu_no_stall", bus.stall, 0);
        cyc(); d_set(1, 5'd9, 0, 5'd0, 0, 5'd0, 0, 0); #1;
        chk("br_stall", bus.stall, 1);
        cyc(); #1;
        chk("br_release", bus.stall, 0);
        chk("br_fwd_d_rs", bus.fwd_d_rs, 1);
        chk("br_fwd_d_rt", bus.fwd_d_rt, 0);
        cyc(); d_idle(); #1;
        chk("br_fwd_e_rs_w", bus.fwd_e_rs, 2);

        // Priority: M.dst = W.dst = 5 with E.rs = 5
        cyc(); d_set(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0); #1;
        cyc(); d_set(1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0); #1;
        chk("pri_no_stall", bus.stall, 0);
        cyc(); d_set(1, 5'd5, 1, 5'd0, 3, 5'd6, 1, 0); #1;
        chk("pri_stall", bus.stall, 0);
        chk("pri_fwd_d_rs", bus.fwd_d_rs, 1);
        cyc(); d_idle(); #1;
        chk("pri_fwd_e_rs", bus.fwd_e_rs, 1);
        chk("pri_fwd_e_rt", bus.fwd_e_rt, 0);

        // Register zero: producer with dst 0, consumer reading $0
        cyc(); d_set(1, 5'd1, 1, 5'd0, 3, 5'd0, 1, 0); #1;
        cyc(); d_set(1, 5'd0, 0, 5'd0, 0, 5'd12, 1, 0); #1;
        chk("r0_stall", bus.stall, 0);
        chk("r0_fwd_d_rs", bus.fwd_d_rs, 0);
        chk("r0_fwd_d_rt", bus.fwd_d_rt, 0);

        // Invalid D never stalls even with a matching producer in E
        cyc(); d_set(1, 5'd1, 1, 5'd2, 1, 5'd14, 2, 0); #1;
        cyc(); d_set(0, 5'd14, 0, 5'd0, 3, 5'd0, 0, 0); #1;
        chk("inv_no_stall", bus.stall, 0);
        cyc(); d_set(1, 5'd14, 0, 5'd0, 3, 5'd0, 0, 0); #1;
        chk("valid_stall_m", bus.stall, 1);

        // MD interlock: mult in E starting, mflo $7 in D, 5 busy cycles
        cyc(); d_set(1, 5'd1, 1, 5'd2, 1, 5'd0, 0, 1); #1;
        chk("mult_no_stall", bus.stall, 0);
        cyc(); bus.md_start = 1'b1; d_set(1, 5'd0, 3, 5'd0, 3, 5'd7, 1, 1); #1;
        chk("md_start_stall", bus.stall, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(); bus.md_start = 1'b0; bus.md_busy = 1'b1; #1;
            chk($sformatf("md_busy_stall%0d", i), bus.stall, 1);
        end
        cyc(); bus.md_busy = 1'b0; #1;
        chk("md_release", bus.stall, 0);
`ifdef HAZARD_STATS_EN
        chk("cnt_after_md", stall_cnt, 9);
`endif
        cyc(); bus.md_busy = 1'b1; d_set(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0); #1;
        chk("busy_non_md", bus.stall, 0);
        bus.md_busy = 1'b0;

        // Reset in the middle of a load-use stall
        cyc(); d_set(1, 5'd29, 1, 5'd0, 3, 5'd8, 2, 0); #1;
        cyc(); d_set(1, 5'd8, 1, 5'd9, 1, 5'd10, 1, 0); #1;
        chk("rst_mid_pre", bus.stall, 1);
        reset = 1'b1;
        cyc(); reset = 1'b0; #1;
        chk("rst_mid_stall", bus.stall, 0);
        chk("rst_mid_fwd_d_rs", bus.fwd_d_rs, 0);
`ifdef HAZARD_STATS_EN
        chk("rst_mid_cnt", stall_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish before 100000ns");
        $fatal(1);
    end
endmodule
